// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 bring-up sequencer: starts the power-up block, then walks the register
// init table from an external ROM, issuing SCCB writes with delay, retry and timeout handling.
module ov5640_cfg_ctrl #(
    parameter int TABLE_LEN   = 256,
    parameter int IDX_W       = 8,
    parameter int CLK_PER_MS  = 100000,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_start,
    output logic             ov5640_setup_start,
    input  logic             ov5640_setup_done,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [23:0]      rom_data,
    output logic             sccb_req,
    input  logic             sccb_ready,
    output logic [15:0]      sccb_addr,
    output logic [7:0]       sccb_wdata,
    input  logic             sccb_done,
    input  logic             sccb_nack,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_error,
    output logic [IDX_W-1:0] cfg_err_idx
);

    localparam int CNT_MAX = (CLK_PER_MS > TIMEOUT_CYC) ? CLK_PER_MS : TIMEOUT_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_SETUP,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]        sccb_addr_q, sccb_addr_d;
    logic [7:0]         sccb_wdata_q, sccb_wdata_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         ms_q, ms_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               setup_start_q, setup_start_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            rom_addr_q    <= '0;
            sccb_addr_q   <= '0;
            sccb_wdata_q  <= '0;
            retry_q       <= '0;
            ms_q          <= '0;
            cyc_q         <= '0;
            setup_start_q <= 1'b0;
            err_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rom_addr_q    <= rom_addr_d;
            sccb_addr_q   <= sccb_addr_d;
            sccb_wdata_q  <= sccb_wdata_d;
            retry_q       <= retry_d;
            ms_q          <= ms_d;
            cyc_q         <= cyc_d;
            setup_start_q <= setup_start_d;
            err_idx_q     <= err_idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rom_addr_d    = rom_addr_q;
        sccb_addr_d   = sccb_addr_q;
        sccb_wdata_d  = sccb_wdata_q;
        retry_d       = retry_q;
        ms_d          = ms_q;
        cyc_d         = cyc_q;
        setup_start_d = setup_start_q;
        err_idx_d     = err_idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    setup_start_d = 1'b1;
                    state_d       = S_WAIT_SETUP;
                end
            end
            S_WAIT_SETUP: begin
                if (ov5640_setup_done) begin
                    idx_d      = '0;
                    rom_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            // rom_addr already holds idx; data is valid in DECODE
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data[23:8] == 16'hFFFF) begin
                    ms_d    = rom_data[7:0];
                    cyc_d   = '0;
                    state_d = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
                end else begin
                    sccb_addr_d  = rom_data[23:8];
                    sccb_wdata_d = rom_data[7:0];
                    retry_d      = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb_ready) begin
                    cyc_d   = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                cyc_d = cyc_q + CNT_W'(1);
                // a done pulse on the timeout cycle still counts as a completion
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        state_d = S_NEXT;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        err_idx_d = idx_q;
                        state_d   = S_ERROR;
                    end
                end else if (cyc_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_idx_d = idx_q;
                    state_d   = S_ERROR;
                end
            end
            S_DELAY: begin
                if (cyc_q == CNT_W'(CLK_PER_MS - 1)) begin
                    cyc_d = '0;
                    ms_d  = ms_q - 8'd1;
                    if (ms_q == 8'd1) state_d = S_NEXT;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_W'(TABLE_LEN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    rom_addr_d = idx_q + IDX_W'(1);
                    state_d    = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    assign ov5640_setup_start = setup_start_q;
    assign rom_addr           = rom_addr_q;
    assign sccb_req           = (state_q == S_ISSUE);
    assign sccb_addr          = sccb_addr_q;
    assign sccb_wdata         = sccb_wdata_q;
    assign cfg_busy           = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign cfg_done           = (state_q == S_DONE);
    assign cfg_error          = (state_q == S_ERROR);
    assign cfg_err_idx        = err_idx_q;

endmodule

// File: doc/ov5640_cfg_ctrl.md
Name: ov5640_cfg_ctrl

Overview:
- Top-level bring-up sequencer for the OV5640 camera.
- Kicks off the power-up/reset sequencing block, waits for it to finish, then walks a register initialisation table held in an external ROM.
- Issues each 16-bit-address/8-bit-data write to the SCCB master, honours delay entries, retries NACKed writes and flags fatal errors.
- Sits between system control and the SCCB master / power-up block.

Parameters:
- TABLE_LEN, 256, number of table entries; indices 0..TABLE_LEN-1.
- IDX_W, 8, width of rom_addr and cfg_err_idx.
- CLK_PER_MS, 100000, sys_clk cycles per millisecond (100 MHz).
- MAX_RETRY, 3, extra attempts allowed after a NACK before error.
- TIMEOUT_CYC, 1000000, maximum cycles from accepted request to sccb_done.

Ports:
- sys_clk  in  1  system clock, 100 MHz; all logic on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  level; high in IDLE starts the bring-up.
- ov5640_setup_start  out  1  held high to the power-up block from WAIT_SETUP onward.
- ov5640_setup_done  in  1  power-up sequence complete (level).
- rom_addr  out  IDX_W  table index.
- rom_data  in  24  {reg_addr[23:8], reg_data[7:0]}; valid 1 cycle after rom_addr.
- sccb_req  out  1  write request; held until accepted.
- sccb_ready  in  1  master can accept; transfer accepted when sccb_req && sccb_ready.
- sccb_addr  out  16  register address, stable while sccb_req is high.
- sccb_wdata  out  8  register data, stable while sccb_req is high.
- sccb_done  in  1  one-cycle pulse; transfer finished.
- sccb_nack  in  1  qualified by sccb_done; 1 = slave NACK.
- cfg_busy  out  1  high in any state except IDLE, DONE and ERROR.
- cfg_done  out  1  table completed successfully (sticky).
- cfg_error  out  1  fatal error (sticky).
- cfg_err_idx  out  IDX_W  table index of the failing entry.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; every output 0, including rom_addr, sccb_addr, sccb_wdata and cfg_err_idx. An in-flight sccb_req drops immediately. A mid-run reset restarts from IDLE.
- IDLE: when cfg_start=1, go to WAIT_SETUP.
- WAIT_SETUP: drive ov5640_setup_start=1 (it stays 1 until reset). When ov5640_setup_done=1, set idx=0 and go to FETCH.
- FETCH (1 cycle): rom_addr=idx, then go to DECODE.
- DECODE (1 cycle): latch rom_data and decode it.
  - reg_addr==16'hFFFF is a delay entry. Load the ms counter with reg_data; if reg_data==0 go to NEXT, else go to DELAY.
  - Otherwise: sccb_addr=reg_addr, sccb_wdata=reg_data, retry=0, go to ISSUE.
- ISSUE: sccb_req=1. On the cycle where sccb_req && sccb_ready, drop sccb_req next cycle, clear the timeout counter and go to WAIT_DONE.
- WAIT_DONE: the timeout counter increments each cycle.
  - sccb_done && !sccb_nack: go to NEXT.
  - sccb_done && sccb_nack && retry<MAX_RETRY: retry+1, go to ISSUE. Same addr/data, no ROM re-read.
  - sccb_done && sccb_nack && retry==MAX_RETRY: go to ERROR.
  - Counter reaching TIMEOUT_CYC-1 without sccb_done: go to ERROR.
  - sccb_done on the same cycle as the timeout: sccb_done wins.
- DELAY: the cycle counter runs 0..CLK_PER_MS-1. At wrap, decrement the ms count; when ms reaches 0, go to NEXT. Total wait = reg_data*CLK_PER_MS cycles (±2 cycles of FSM overhead).
- NEXT (1 cycle): if idx==TABLE_LEN-1, go to DONE; else idx+1 and go to FETCH. idx never wraps.
- DONE: cfg_done=1. Terminal until reset; cfg_start is ignored.
- ERROR: cfg_error=1, cfg_err_idx=idx. Terminal until reset.
- cfg_done and cfg_error are never both 1.
- sccb_done arriving outside WAIT_DONE is ignored.
- ov5640_setup_done falling after WAIT_SETUP is ignored.
- Counter widths: the ms counter is 8 bits; the cycle and timeout counters are sized with $clog2 of the larger of CLK_PER_MS and TIMEOUT_CYC.
- Write latency: ROM fetch-to-request is 2 cycles (FETCH, DECODE), with sccb_req asserted in the ISSUE cycle that follows.

Test Plan:
- Nominal run: TABLE_LEN=4 with entries {3008,82},{FFFF,02},{3103,11},{3017,FF}; setup_done 10 cycles after cfg_start; SCCB model acks with 50-cycle latency. Required: exactly 3 writes with matching addr/data, in order; writes 1 and 2 separated by ≥200000 cycles; cfg_done=1, cfg_busy=0, cfg_error=0.
- Handshake hold: sccb_ready held low for 20 cycles. Required: sccb_req, sccb_addr and sccb_wdata are stable for all 20 cycles; sccb_req drops the cycle after acceptance.
- Retry then success: entry 0 NACKs twice, then acks. Required: 3 requests with identical addr/data; cfg_done=1.
- Retry exhaustion: entry 2 NACKs always with MAX_RETRY=3. Required: 4 attempts; cfg_error=1, cfg_err_idx=2; no further sccb_req; cfg_done stays 0.
- Timeout: sccb_done is never returned, with TIMEOUT_CYC=100. Required: cfg_error=1 at 100±1 cycles after acceptance, cfg_err_idx=0.
- Reset mid-run: assert sys_rst during DELAY and during ISSUE. Required: all outputs 0 asynchronously; the next cfg_start reruns from index 0; a zero-ms delay entry (FFFF,00) advances with no wait.
